// File: rtl/tpu_pkg.sv
// Shared TPU constants and the tile sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tpu_pkg;

    // Default PE array edge length and SRAM address width.
    localparam int TPU_MATRIX_SIZE = 8;
    localparam int TPU_ADDRESSSIZE = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_RELOAD = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/tpu_addr_gen.sv
// Tile address generator: addr_o = base_i + tile_i*MATRIX_SIZE + off_i, modulo 2^ADDRESSSIZE.
// Latency: purely combinational.
// Backpressure: none.
// Ports: base_i (region base), tile_i (tile index), off_i (row offset in tile), addr_o (wrapped address).
module tpu_addr_gen
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE = TPU_ADDRESSSIZE,
    parameter int MATRIX_SIZE = TPU_MATRIX_SIZE,
    parameter int TILE_W      = 8,
    parameter int OFF_W       = 5
) (
    input  logic [ADDRESSSIZE-1:0] base_i,
    input  logic [TILE_W-1:0]      tile_i,
    input  logic [OFF_W-1:0]       off_i,
    output logic [ADDRESSSIZE-1:0] addr_o
);

    // Every term is cast to the address width first, so the sum wraps
    // naturally; truncating tile_i before the multiply is harmless because
    // only the low ADDRESSSIZE bits of the product survive anyway.
    assign addr_o = base_i
                  + ADDRESSSIZE'(tile_i) * ADDRESSSIZE'(MATRIX_SIZE)
                  + ADDRESSSIZE'(off_i);

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: per tile pops a weight, pulses reload, streams MATRIX_SIZE UB reads, then writes MATRIX_SIZE result rows.
// Latency: job start to first pop 1 cycle; per tile 2 + MATRIX_SIZE + RESULT_LATENCY + MATRIX_SIZE cycles; done 1 cycle after last drain.
// Backpressure: waits in LOAD_W while the weight FIFO is empty; abort returns to IDLE next cycle without done.
// Ports: clk/rst; start/abort/num_tiles/ub_base_addr/res_base_addr job control; fifo_empty/fifo_read_enable weight FIFO;
//        we_rl reload; ub_rd_en/ub_rd_addr UB reads; res_we/res_addr result writes; tile_idx/busy/done status.
module tpu_tile_sequencer
    import tpu_pkg::*;
#(
    parameter int MATRIX_SIZE    = TPU_MATRIX_SIZE,
    parameter int ADDRESSSIZE    = TPU_ADDRESSSIZE,
    parameter int TILE_W         = 8,
    parameter int RESULT_LATENCY = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [TILE_W-1:0]      num_tiles,
    input  logic [ADDRESSSIZE-1:0] ub_base_addr,
    input  logic [ADDRESSSIZE-1:0] res_base_addr,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_rd_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic [TILE_W-1:0]      tile_idx,
    output logic                   busy,
    output logic                   done
);

    // One counter serves both STREAM (0..MATRIX_SIZE-1) and DRAIN (0..RESULT_LATENCY+MATRIX_SIZE-1).
    localparam int CNT_W = $clog2(RESULT_LATENCY + MATRIX_SIZE + 1);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(MATRIX_SIZE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(RESULT_LATENCY + MATRIX_SIZE - 1);
    localparam logic [CNT_W-1:0] LAT_C       = CNT_W'(RESULT_LATENCY);

    seq_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [TILE_W-1:0]      tile_idx_q;
    logic [TILE_W-1:0]      num_tiles_q;
    logic [ADDRESSSIZE-1:0] ub_base_q;
    logic [ADDRESSSIZE-1:0] res_base_q;
    logic                   we_rl_q;
    logic                   ub_rd_en_q;
    logic [ADDRESSSIZE-1:0] ub_rd_addr_q;
    logic                   res_we_q;
    logic [ADDRESSSIZE-1:0] res_addr_q;
    logic                   busy_q;
    logic                   done_q;

    // Outputs are registered, so the address for the cycle after this one
    // is generated from the counter value that cycle will hold.
    logic [CNT_W-1:0]       ub_off_d;
    logic [CNT_W-1:0]       drain_cnt_d;
    logic [CNT_W-1:0]       res_off_d;
    logic                   res_hit_d;
    logic [TILE_W:0]        tile_next_d;
    logic                   more_tiles_d;
    logic [ADDRESSSIZE-1:0] ub_addr_w;
    logic [ADDRESSSIZE-1:0] res_addr_w;

    always_comb begin
        ub_off_d     = (state_q == ST_STREAM) ? cnt_q + CNT_W'(1) : '0;
        drain_cnt_d  = (state_q == ST_DRAIN)  ? cnt_q + CNT_W'(1) : '0;
        res_hit_d    = (drain_cnt_d >= LAT_C);
        res_off_d    = drain_cnt_d - LAT_C;
        // One extra bit so tile_idx+1 cannot wrap when num_tiles is at its maximum.
        tile_next_d  = {1'b0, tile_idx_q} + (TILE_W + 1)'(1);
        more_tiles_d = (tile_next_d < {1'b0, num_tiles_q});
    end

    tpu_addr_gen #(
        .ADDRESSSIZE (ADDRESSSIZE),
        .MATRIX_SIZE (MATRIX_SIZE),
        .TILE_W      (TILE_W),
        .OFF_W       (CNT_W)
    ) u_ub_addr (
        .base_i (ub_base_q),
        .tile_i (tile_idx_q),
        .off_i  (ub_off_d),
        .addr_o (ub_addr_w)
    );

    tpu_addr_gen #(
        .ADDRESSSIZE (ADDRESSSIZE),
        .MATRIX_SIZE (MATRIX_SIZE),
        .TILE_W      (TILE_W),
        .OFF_W       (CNT_W)
    ) u_res_addr (
        .base_i (res_base_q),
        .tile_i (tile_idx_q),
        .off_i  (res_off_d),
        .addr_o (res_addr_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tile_idx_q   <= '0;
            num_tiles_q  <= '0;
            ub_base_q    <= '0;
            res_base_q   <= '0;
            we_rl_q      <= 1'b0;
            ub_rd_en_q   <= 1'b0;
            ub_rd_addr_q <= '0;
            res_we_q     <= 1'b0;
            res_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-arms them below.
            we_rl_q    <= 1'b0;
            ub_rd_en_q <= 1'b0;
            res_we_q   <= 1'b0;
            done_q     <= 1'b0;
            if (abort) begin
                // In IDLE this is a no-op that also swallows a coincident start.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            num_tiles_q <= num_tiles;
                            ub_base_q   <= ub_base_addr;
                            res_base_q  <= res_base_addr;
                            tile_idx_q  <= '0;
                            cnt_q       <= '0;
                            busy_q      <= 1'b1;
                            if (num_tiles == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD_W;
                            end
                        end
                    end
                    ST_LOAD_W: begin
                        if (!fifo_empty) begin
                            state_q <= ST_RELOAD;
                            we_rl_q <= 1'b1;
                        end
                    end
                    ST_RELOAD: begin
                        state_q      <= ST_STREAM;
                        cnt_q        <= '0;
                        ub_rd_en_q   <= 1'b1;
                        ub_rd_addr_q <= ub_addr_w;
                    end
                    ST_STREAM: begin
                        if (cnt_q == STREAM_LAST) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q        <= cnt_q + CNT_W'(1);
                            ub_rd_en_q   <= 1'b1;
                            ub_rd_addr_q <= ub_addr_w;
                        end
                        // Only matters when RESULT_LATENCY is 0: first result row lands on DRAIN entry.
                        if (cnt_q == STREAM_LAST && res_hit_d) begin
                            res_we_q   <= 1'b1;
                            res_addr_q <= res_addr_w;
                        end
                    end
                    ST_DRAIN: begin
                        if (cnt_q == DRAIN_LAST) begin
                            cnt_q <= '0;
                            if (more_tiles_d) begin
                                tile_idx_q <= tile_next_d[TILE_W-1:0];
                                state_q    <= ST_LOAD_W;
                            end else begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (res_hit_d) begin
                                res_we_q   <= 1'b1;
                                res_addr_q <= res_addr_w;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The pop is the one combinational strobe: the FIFO head is consumed in the
    // same cycle it is seen non-empty. Abort and reset suppress it.
    assign fifo_read_enable = (state_q == ST_LOAD_W) && !fifo_empty && !abort && !rst;

    assign we_rl      = we_rl_q;
    assign ub_rd_en   = ub_rd_en_q;
    assign ub_rd_addr = ub_rd_addr_q;
    assign res_we     = res_we_q;
    assign res_addr   = res_addr_q;
    assign tile_idx   = tile_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Bench for tpu_tile_sequencer: address scoreboard fed at job start, drained by a negedge monitor,
// plus cycle-exact strobe checks for the single-tile, stall, zero-tile, abort and reset cases.
module tb_tpu_tile_sequencer;

    localparam int M  = 8;
    localparam int AW = 10;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort, fifo_empty;
    logic [TW-1:0] num_tiles;
    logic [AW-1:0] ub_base_addr, res_base_addr;
    logic          fifo_read_enable, we_rl, ub_rd_en, res_we, busy, done;
    logic [AW-1:0] ub_rd_addr, res_addr;
    logic [TW-1:0] tile_idx;

    int total = 0;
    int bad   = 0;
    int pop_cnt = 0;
    int rl_cnt  = 0;

    logic [31:0] ub_sb[$];
    logic [31:0] res_sb[$];
    logic [31:0] done_sb[$];

    always #5 clk = ~clk;

    tpu_tile_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .num_tiles        (num_tiles),
        .ub_base_addr     (ub_base_addr),
        .res_base_addr    (res_base_addr),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .we_rl            (we_rl),
        .ub_rd_en         (ub_rd_en),
        .ub_rd_addr       (ub_rd_addr),
        .res_we           (res_we),
        .res_addr         (res_addr),
        .tile_idx         (tile_idx),
        .busy             (busy),
        .done             (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (fifo_read_enable) pop_cnt++;
        if (we_rl) rl_cnt++;
        if (ub_rd_en) begin
            if (ub_sb.size() > 0) chk("ub_addr", 32'(ub_rd_addr), ub_sb.pop_front());
            else                  chk("ub_unexpected", 32'(ub_rd_en), 32'd0);
        end
        if (res_we) begin
            if (res_sb.size() > 0) chk("res_addr", 32'(res_addr), res_sb.pop_front());
            else                   chk("res_unexpected", 32'(res_we), 32'd0);
        end
        if (done) begin
            if (done_sb.size() > 0) void'(done_sb.pop_front());
            else                    chk("done_unexpected", 32'(done), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    function automatic logic [5:0] strobes();
        return {busy, done, fifo_read_enable, we_rl, ub_rd_en, res_we};
    endfunction

    // Reference model: a job touches base + t*M + k for every tile t and row k, wrapping at 2^AW.
    task automatic push_job(input int nt, input int ub, input int rb);
        for (int t = 0; t < nt; t++) begin
            for (int k = 0; k < M; k++) begin
                ub_sb.push_back(32'((ub + t * M + k) % (1 << AW)));
                res_sb.push_back(32'((rb + t * M + k) % (1 << AW)));
            end
        end
        done_sb.push_back(32'd1);
    endtask

    task automatic drive_start(input int nt, input int ub, input int rb);
        num_tiles     = TW'(nt);
        ub_base_addr  = AW'(ub);
        res_base_addr = AW'(rb);
        start         = 1'b1;
    endtask

    task automatic wait_done(input int budget, input int exp_tile);
        int n;
        n = 0;
        look();
        while (!done && n < budget) begin
            look();
            n++;
        end
        if (done) chk("done_tile_idx", 32'(tile_idx), 32'(exp_tile));
        else      chk("done_timeout", 32'(done), 32'd1);
        step();
        look();
        chk("idle_after_done", 32'(strobes()), 32'd0);
    endtask

    task automatic sb_empty(input string tag);
        chk({tag, "_ub_left"},   32'(ub_sb.size()),   32'd0);
        chk({tag, "_res_left"},  32'(res_sb.size()),  32'd0);
        chk({tag, "_done_left"}, 32'(done_sb.size()), 32'd0);
    endtask

    initial begin
        logic [5:0] exp6;
        rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
        num_tiles = '0; ub_base_addr = '0; res_base_addr = '0;

        // Reset state
        step(); step();
        look();
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_ub_addr", 32'(ub_rd_addr), 32'd0);
        chk("rst_res_addr", 32'(res_addr), 32'd0);
        chk("rst_tile_idx", 32'(tile_idx), 32'd0);
        step();
        rst = 1'b0;

        // Single tile, cycle-exact timeline
        step();
        push_job(1, 'h010, 'h100);
        drive_start(1, 'h010, 'h100);
        for (int c = 1; c <= 35; c++) begin
            step();
            if (c == 1) start = 1'b0;
            look();
            exp6[5] = (c >= 1 && c <= 34);
            exp6[4] = (c == 34);
            exp6[3] = (c == 1);
            exp6[2] = (c == 2);
            exp6[1] = (c >= 3 && c <= 10);
            exp6[0] = (c >= 26 && c <= 33);
            chk($sformatf("t1_cyc%0d", c), 32'(strobes()), 32'(exp6));
        end
        sb_empty("t1");

        // Three tiles
        step();
        pop_cnt = 0; rl_cnt = 0;
        push_job(3, 'h010, 'h100);
        drive_start(3, 'h010, 'h100);
        step();
        start = 1'b0;
        wait_done(300, 2);
        chk("t2_pops", 32'(pop_cnt), 32'd3);
        chk("t2_reloads", 32'(rl_cnt), 32'd3);
        sb_empty("t2");

        // Weight FIFO empty for 5 cycles in LOAD_W
        step();
        fifo_empty = 1'b1;
        push_job(1, 'h200, 'h050);
        drive_start(1, 'h200, 'h050);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (c == 6) fifo_empty = 1'b0;
            look();
            exp6 = (c <= 5) ? 6'b100000 : (c == 6) ? 6'b101000 : 6'b100100;
            chk($sformatf("t3_cyc%0d", c), 32'(strobes()), 32'(exp6));
        end
        wait_done(100, 0);
        sb_empty("t3");

        // Zero tiles: done one cycle after start
        step();
        done_sb.push_back(32'd1);
        drive_start(0, 'h123, 'h321);
        step();
        start = 1'b0;
        look();
        chk("t4_cyc1", 32'(strobes()), 32'b110000);
        step();
        look();
        chk("t4_cyc2", 32'(strobes()), 32'd0);
        sb_empty("t4");

        // UB and result address wrap
        step();
        push_job(1, 'h3FC, 'h3FA);
        drive_start(1, 'h3FC, 'h3FA);
        step();
        start = 1'b0;
        wait_done(100, 0);
        sb_empty("t5");

        // Start while busy is ignored, then abort mid-STREAM
        step();
        ub_sb.push_back(32'h040); ub_sb.push_back(32'h041); ub_sb.push_back(32'h042);
        drive_start(2, 'h040, 'h080);
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0;
            abort = 1'b0;
            if (c == 3) drive_start(7, 'h300, 'h000);
            if (c == 5) abort = 1'b1;
        end
        look();
        chk("t6_abort_outputs", 32'(strobes()), 32'd0);
        chk("t6_ub_addr_hold", 32'(ub_rd_addr), 32'h042);
        repeat (40) step();
        look();
        chk("t6_still_idle", 32'(busy), 32'd0);
        sb_empty("t6");

        // Reset mid-STREAM wins over coincident abort and start
        step();
        ub_sb.push_back(32'h0A0); ub_sb.push_back(32'h0A1);
        drive_start(1, 'h0A0, 'h0C0);
        for (int c = 1; c <= 5; c++) begin
            step();
            start = 1'b0;
            rst   = 1'b0;
            abort = 1'b0;
            if (c == 4) begin
                rst = 1'b1; abort = 1'b1; start = 1'b1;
            end
        end
        look();
        chk("t7_rst_strobes", 32'(strobes()), 32'd0);
        chk("t7_rst_ub_addr", 32'(ub_rd_addr), 32'd0);
        chk("t7_rst_res_addr", 32'(res_addr), 32'd0);
        chk("t7_rst_tile_idx", 32'(tile_idx), 32'd0);
        repeat (30) step();
        look();
        chk("t7_still_idle", 32'(busy), 32'd0);
        sb_empty("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
